// File: rtl/tl_beat_tracker.sv
// -----------------------------------------------------------------------------
// tl_beat_tracker
//   Sits beside the TileLink bus monitor on the same A/D tap points. Every
//   A or D channel fire is annotated with its position inside the message
//   (first / last / beat index) and re-emitted one cycle later as a
//   registered beat event. Outstanding requests are tracked per source and
//   protocol violations raise sticky error flags.
//
// Ports
//   clock, reset_n                  clock (rising edge), async active-low reset
//   a_opcode/a_size/a_source        A channel message attributes
//   a_valid/a_ready                 A handshake, fire = a_valid & a_ready
//   d_opcode/d_size/d_source        D channel message attributes
//   d_denied                        D denied, passed through to ed_denied
//   d_valid/d_ready                 D handshake, fire = d_valid & d_ready
//   ea_*                            registered A beat event
//   ed_*                            registered D beat event
//   outstanding                     number of sources with a request in flight
//   err_dup_source                  sticky: A request on an in-flight source
//   err_orphan_d                    sticky: D response with no request
//   err_burst                       sticky: attributes changed mid-burst
// -----------------------------------------------------------------------------
module tl_beat_tracker #(
    parameter int SIZE_WD   = 3,
    parameter int SOURCE_WD = 4,
    parameter int DATA_WD   = 256,
    parameter int BEAT_WD   = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [2:0]           a_opcode,
    input  logic [SIZE_WD-1:0]   a_size,
    input  logic [SOURCE_WD-1:0] a_source,
    input  logic                 a_valid,
    input  logic                 a_ready,
    input  logic [2:0]           d_opcode,
    input  logic [SIZE_WD-1:0]   d_size,
    input  logic [SOURCE_WD-1:0] d_source,
    input  logic                 d_denied,
    input  logic                 d_valid,
    input  logic                 d_ready,
    output logic                 ea_valid,
    output logic                 ea_first,
    output logic                 ea_last,
    output logic [BEAT_WD-1:0]   ea_beat,
    output logic [SOURCE_WD-1:0] ea_source,
    output logic [2:0]           ea_opcode,
    output logic                 ed_valid,
    output logic                 ed_first,
    output logic                 ed_last,
    output logic [BEAT_WD-1:0]   ed_beat,
    output logic [SOURCE_WD-1:0] ed_source,
    output logic [2:0]           ed_opcode,
    output logic                 ed_denied,
    output logic [SOURCE_WD:0]   outstanding,
    output logic                 err_dup_source,
    output logic                 err_orphan_d,
    output logic                 err_burst
);

    localparam int NSRC = 1 << SOURCE_WD;
    localparam int BPB  = DATA_WD / 8;
    localparam logic [SIZE_WD-1:0] LOG_BPB = SIZE_WD'($clog2(BPB));

    // Index of the last beat of a message: data messages larger than one bus
    // beat span 2^size/BPB beats, everything else is a single beat.
    function automatic logic [BEAT_WD-1:0] last_idx_f(
        input logic               is_data,
        input logic [SIZE_WD-1:0] size
    );
        logic [BEAT_WD-1:0] idx;
        idx = {BEAT_WD{1'b0}};
        if (is_data && (size > LOG_BPB)) begin
            idx = (BEAT_WD'(1) << (size - LOG_BPB)) - BEAT_WD'(1);
        end else begin
            idx = {BEAT_WD{1'b0}};
        end
        return idx;
    endfunction

    // Number of set bits in the outstanding table.
    function automatic logic [SOURCE_WD:0] popcnt_f(input logic [NSRC-1:0] v);
        logic [SOURCE_WD:0] c;
        c = {(SOURCE_WD+1){1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            c = c + {{SOURCE_WD{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Per-channel beat counters and burst-capture registers
    logic [BEAT_WD-1:0]   a_cnt_r,  d_cnt_r;
    logic [2:0]           a_lat_op_r,  d_lat_op_r;
    logic [SOURCE_WD-1:0] a_lat_src_r, d_lat_src_r;
    logic [SIZE_WD-1:0]   a_lat_size_r, d_lat_size_r;
    logic [BEAT_WD-1:0]   a_lat_last_r, d_lat_last_r;
    logic [NSRC-1:0]      tbl_r;

    logic                 a_fire_s, a_first_s, a_last_s, a_mis_s, a_is_data_s;
    logic                 d_fire_s, d_first_s, d_last_s, d_mis_s, d_is_data_s;
    logic                 d_tracked_s;
    logic [BEAT_WD-1:0]   a_last_idx_s, d_last_idx_s;
    logic [NSRC-1:0]      tbl_clr_s, tbl_nxt_s;
    logic                 dup_s, orphan_s, burst_s;

    // Beat position decode for both channels. A non-first beat uses the
    // beat total captured on the first beat, even if the size has changed.
    always_comb begin
        a_fire_s     = a_valid & a_ready;
        a_first_s    = (a_cnt_r == {BEAT_WD{1'b0}});
        a_is_data_s  = (a_opcode <= 3'd3);
        a_last_idx_s = a_first_s ? last_idx_f(a_is_data_s, a_size) : a_lat_last_r;
        a_last_s     = (a_cnt_r == a_last_idx_s);
        a_mis_s      = !a_first_s && ((a_opcode != a_lat_op_r) ||
                                      (a_source != a_lat_src_r) ||
                                      (a_size   != a_lat_size_r));

        d_fire_s     = d_valid & d_ready;
        d_first_s    = (d_cnt_r == {BEAT_WD{1'b0}});
        d_is_data_s  = (d_opcode == 3'd1) || (d_opcode == 3'd5);
        d_last_idx_s = d_first_s ? last_idx_f(d_is_data_s, d_size) : d_lat_last_r;
        d_last_s     = (d_cnt_r == d_last_idx_s);
        d_mis_s      = !d_first_s && ((d_opcode != d_lat_op_r) ||
                                      (d_source != d_lat_src_r) ||
                                      (d_size   != d_lat_size_r));
    end

    // D opcodes that answer a tracked request (ReleaseAck and reserved
    // encodings are ignored by the outstanding table).
    always_comb begin
        case (d_opcode)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: d_tracked_s = 1'b1;
            default:                      d_tracked_s = 1'b0;
        endcase
    end

    // Outstanding table update: the D clear is applied first so that an A
    // request reusing a source retired on the same edge is not a duplicate.
    always_comb begin
        tbl_clr_s = tbl_r;
        if (d_fire_s && d_last_s && d_tracked_s) begin
            tbl_clr_s[d_source] = 1'b0;
        end else begin
            tbl_clr_s = tbl_r;
        end

        tbl_nxt_s = tbl_clr_s;
        if (a_fire_s && a_first_s) begin
            tbl_nxt_s[a_source] = 1'b1;
        end else begin
            tbl_nxt_s = tbl_clr_s;
        end

        dup_s    = a_fire_s && a_first_s && tbl_clr_s[a_source];
        orphan_s = d_fire_s && d_first_s && d_tracked_s && !tbl_r[d_source];
        burst_s  = (a_fire_s && a_mis_s) || (d_fire_s && d_mis_s);
    end

    // A channel beat counter and first-beat attribute capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_cnt_r      <= {BEAT_WD{1'b0}};
            a_lat_op_r   <= 3'd0;
            a_lat_src_r  <= {SOURCE_WD{1'b0}};
            a_lat_size_r <= {SIZE_WD{1'b0}};
            a_lat_last_r <= {BEAT_WD{1'b0}};
        end else if (a_fire_s) begin
            a_cnt_r <= a_last_s ? {BEAT_WD{1'b0}} : (a_cnt_r + BEAT_WD'(1));
            if (a_first_s) begin
                a_lat_op_r   <= a_opcode;
                a_lat_src_r  <= a_source;
                a_lat_size_r <= a_size;
                a_lat_last_r <= a_last_idx_s;
            end
        end
    end

    // D channel beat counter and first-beat attribute capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_cnt_r      <= {BEAT_WD{1'b0}};
            d_lat_op_r   <= 3'd0;
            d_lat_src_r  <= {SOURCE_WD{1'b0}};
            d_lat_size_r <= {SIZE_WD{1'b0}};
            d_lat_last_r <= {BEAT_WD{1'b0}};
        end else if (d_fire_s) begin
            d_cnt_r <= d_last_s ? {BEAT_WD{1'b0}} : (d_cnt_r + BEAT_WD'(1));
            if (d_first_s) begin
                d_lat_op_r   <= d_opcode;
                d_lat_src_r  <= d_source;
                d_lat_size_r <= d_size;
                d_lat_last_r <= d_last_idx_s;
            end
        end
    end

    // Outstanding table, its population count and sticky error flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tbl_r          <= {NSRC{1'b0}};
            outstanding    <= {(SOURCE_WD+1){1'b0}};
            err_dup_source <= 1'b0;
            err_orphan_d   <= 1'b0;
            err_burst      <= 1'b0;
        end else begin
            tbl_r          <= tbl_nxt_s;
            outstanding    <= popcnt_f(tbl_nxt_s);
            err_dup_source <= err_dup_source | dup_s;
            err_orphan_d   <= err_orphan_d   | orphan_s;
            err_burst      <= err_burst      | burst_s;
        end
    end

    // Registered A beat event; fields are zero when no beat fired
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ea_valid  <= 1'b0;
            ea_first  <= 1'b0;
            ea_last   <= 1'b0;
            ea_beat   <= {BEAT_WD{1'b0}};
            ea_source <= {SOURCE_WD{1'b0}};
            ea_opcode <= 3'd0;
        end else begin
            ea_valid  <= a_fire_s;
            ea_first  <= a_fire_s & a_first_s;
            ea_last   <= a_fire_s & a_last_s;
            ea_beat   <= a_fire_s ? a_cnt_r  : {BEAT_WD{1'b0}};
            ea_source <= a_fire_s ? a_source : {SOURCE_WD{1'b0}};
            ea_opcode <= a_fire_s ? a_opcode : 3'd0;
        end
    end

    // Registered D beat event; fields are zero when no beat fired
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ed_valid  <= 1'b0;
            ed_first  <= 1'b0;
            ed_last   <= 1'b0;
            ed_beat   <= {BEAT_WD{1'b0}};
            ed_source <= {SOURCE_WD{1'b0}};
            ed_opcode <= 3'd0;
            ed_denied <= 1'b0;
        end else begin
            ed_valid  <= d_fire_s;
            ed_first  <= d_fire_s & d_first_s;
            ed_last   <= d_fire_s & d_last_s;
            ed_beat   <= d_fire_s ? d_cnt_r  : {BEAT_WD{1'b0}};
            ed_source <= d_fire_s ? d_source : {SOURCE_WD{1'b0}};
            ed_opcode <= d_fire_s ? d_opcode : 3'd0;
            ed_denied <= d_fire_s & d_denied;
        end
    end

endmodule

// File: tb/tb_tl_beat_tracker.sv
module tb_tl_beat_tracker;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] a_opcode = 3'd0, a_size = 3'd0, d_opcode = 3'd0, d_size = 3'd0;
    logic [3:0] a_source = 4'd0, d_source = 4'd0;
    logic       a_valid = 1'b0, a_ready = 1'b0, d_valid = 1'b0, d_ready = 1'b0;
    logic       d_denied = 1'b0;
    logic       ea_valid, ea_first, ea_last, ed_valid, ed_first, ed_last, ed_denied;
    logic [7:0] ea_beat, ed_beat;
    logic [3:0] ea_source, ed_source;
    logic [2:0] ea_opcode, ed_opcode;
    logic [4:0] outstanding;
    logic       err_dup_source, err_orphan_d, err_burst;

    int checks = 0;
    int errors = 0;

    tl_beat_tracker dut (
        .clock(clock), .reset_n(reset_n),
        .a_opcode(a_opcode), .a_size(a_size), .a_source(a_source),
        .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_size(d_size), .d_source(d_source),
        .d_denied(d_denied), .d_valid(d_valid), .d_ready(d_ready),
        .ea_valid(ea_valid), .ea_first(ea_first), .ea_last(ea_last),
        .ea_beat(ea_beat), .ea_source(ea_source), .ea_opcode(ea_opcode),
        .ed_valid(ed_valid), .ed_first(ed_first), .ed_last(ed_last),
        .ed_beat(ed_beat), .ed_source(ed_source), .ed_opcode(ed_opcode),
        .ed_denied(ed_denied), .outstanding(outstanding),
        .err_dup_source(err_dup_source), .err_orphan_d(err_orphan_d),
        .err_burst(err_burst)
    );

    always #5 clock = ~clock;

    // ---------------- reference model (message-level view) ----------------
    int m_a_pos, m_a_tot, m_a_op, m_a_src, m_a_sz;
    int m_d_pos, m_d_tot, m_d_op, m_d_src, m_d_sz;
    bit m_tbl [16];
    bit e_ea_v, e_ea_f, e_ea_l, e_ed_v, e_ed_f, e_ed_l, e_ed_den;
    int e_ea_beat, e_ed_beat, e_ea_src, e_ed_src, e_ea_op, e_ed_op, e_out;
    bit e_dup, e_orph, e_burst;

    function automatic int msg_beats(input bit is_data, input int size);
        int bytes;
        bytes = 1 << size;
        return (is_data && bytes > 32) ? bytes / 32 : 1;
    endfunction

    task automatic model_reset();
        m_a_pos = 0; m_a_tot = 1; m_d_pos = 0; m_d_tot = 1;
        for (int i = 0; i < 16; i++) m_tbl[i] = 1'b0;
        e_dup = 0; e_orph = 0; e_burst = 0; e_out = 0;
        e_ea_v = 0; e_ed_v = 0;
    endtask

    // Predict the effect of the upcoming clock edge given the current inputs.
    task automatic model_predict();
        bit af, df, d_trk;
        af = a_valid && a_ready;
        df = d_valid && d_ready;
        d_trk = (d_opcode inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e_ea_v = af; e_ed_v = df;
        e_ea_f = 0; e_ea_l = 0; e_ed_f = 0; e_ed_l = 0; e_ed_den = 0;
        if (af) begin
            e_ea_f = (m_a_pos == 0);
            if (e_ea_f) begin
                m_a_tot = msg_beats(a_opcode <= 3, int'(a_size));
                m_a_op = int'(a_opcode); m_a_src = int'(a_source); m_a_sz = int'(a_size);
            end else if (m_a_op != int'(a_opcode) || m_a_src != int'(a_source) ||
                         m_a_sz != int'(a_size)) begin
                e_burst = 1;
            end
            e_ea_beat = m_a_pos;
            e_ea_l = (m_a_pos == m_a_tot - 1);
            e_ea_src = int'(a_source); e_ea_op = int'(a_opcode);
            m_a_pos = e_ea_l ? 0 : m_a_pos + 1;
        end
        if (df) begin
            e_ed_f = (m_d_pos == 0);
            if (e_ed_f) begin
                m_d_tot = msg_beats(d_opcode == 1 || d_opcode == 5, int'(d_size));
                m_d_op = int'(d_opcode); m_d_src = int'(d_source); m_d_sz = int'(d_size);
            end else if (m_d_op != int'(d_opcode) || m_d_src != int'(d_source) ||
                         m_d_sz != int'(d_size)) begin
                e_burst = 1;
            end
            e_ed_beat = m_d_pos;
            e_ed_l = (m_d_pos == m_d_tot - 1);
            e_ed_src = int'(d_source); e_ed_op = int'(d_opcode); e_ed_den = d_denied;
            m_d_pos = e_ed_l ? 0 : m_d_pos + 1;
        end
        if (df && e_ed_f && d_trk && !m_tbl[d_source]) e_orph = 1;
        if (df && e_ed_l && d_trk) m_tbl[d_source] = 1'b0;
        if (af && e_ea_f) begin
            if (m_tbl[a_source]) e_dup = 1;
            m_tbl[a_source] = 1'b1;
        end
        e_out = 0;
        for (int i = 0; i < 16; i++) e_out += int'(m_tbl[i]);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit av, input int aop, input int asz, input int asrc,
                         input bit dv, input int dop, input int dsz, input int dsrc,
                         input bit dden);
        a_valid = av; a_ready = 1'b1; a_opcode = 3'(aop); a_size = 3'(asz); a_source = 4'(asrc);
        d_valid = dv; d_ready = 1'b1; d_opcode = 3'(dop); d_size = 3'(dsz); d_source = 4'(dsrc);
        d_denied = dden;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1, 0, 6, 1, 1, 1, 6, 1, 1);
        reset_n = 1'b0;
        tick();
        checks++;
        if ({ea_valid, ea_first, ea_last, ea_beat, ea_source, ea_opcode, ed_valid, ed_first,
             ed_last, ed_beat, ed_source, ed_opcode, ed_denied, outstanding,
             err_dup_source, err_orphan_d, err_burst} !== '0) begin
            errors++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        apply_reset();
    endtask

    task automatic test_get_ack_data();
        apply_reset();
        drive(1, 4, 6, 3, 0, 0, 0, 0, 0); tick();
        checks++;
        if ({ea_valid, ea_first, ea_last, ea_beat, ea_source, ea_opcode, outstanding} !==
            {1'b1, 1'b1, 1'b1, 8'd0, 4'd3, 3'd4, 5'd1}) begin
            errors++; $display("FAIL get_event: v%b f%b l%b beat%0d src%0d op%0d out%0d, want 1 1 1 0 3 4 1",
                ea_valid, ea_first, ea_last, ea_beat, ea_source, ea_opcode, outstanding);
        end
        drive(0, 0, 0, 0, 1, 1, 6, 3, 0); tick();
        checks++;
        if ({ea_valid, ed_valid, ed_first, ed_last, ed_beat, outstanding} !==
            {1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 5'd1}) begin
            errors++; $display("FAIL ackdata_beat0: eav%b v%b f%b l%b beat%0d out%0d, want 0 1 1 0 0 1",
                ea_valid, ed_valid, ed_first, ed_last, ed_beat, outstanding);
        end
        tick();
        checks++;
        if ({ed_valid, ed_first, ed_last, ed_beat, outstanding, err_dup_source, err_orphan_d, err_burst} !==
            {1'b1, 1'b0, 1'b1, 8'd1, 5'd0, 3'b000}) begin
            errors++; $display("FAIL ackdata_beat1: v%b f%b l%b beat%0d out%0d err%b%b%b, want 1 0 1 1 0 000",
                ed_valid, ed_first, ed_last, ed_beat, outstanding, err_dup_source, err_orphan_d, err_burst);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        checks++;
        if ({ea_valid, ed_valid} !== 2'b00) begin
            errors++; $display("FAIL idle_valid: ea%b ed%b, want 0 0", ea_valid, ed_valid);
        end
    endtask

    task automatic test_put_burst();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 7, 1, 0, 0, 0, 0, 0); tick();
            checks++;
            if ({ea_valid, ea_first, ea_last, ea_beat, outstanding} !==
                {1'b1, (i == 0), (i == 3), 8'(i), 5'd1}) begin
                errors++; $display("FAIL put_beat%0d: v%b f%b l%b beat%0d out%0d", i,
                    ea_valid, ea_first, ea_last, ea_beat, outstanding);
            end
        end
    endtask

    task automatic test_dup_source();
        apply_reset();
        drive(1, 4, 0, 5, 0, 0, 0, 0, 0); tick();
        checks++;
        if (err_dup_source !== 1'b0) begin
            errors++; $display("FAIL dup_first: got %b want 0", err_dup_source);
        end
        tick();
        checks++;
        if ({err_dup_source, outstanding} !== {1'b1, 5'd1}) begin
            errors++; $display("FAIL dup_second: dup%b out%0d, want 1 1", err_dup_source, outstanding);
        end
    endtask

    task automatic test_orphan();
        apply_reset();
        drive(0, 0, 0, 0, 1, 0, 0, 9, 1); tick();
        checks++;
        if ({err_orphan_d, outstanding, ed_denied, ed_source} !== {1'b1, 5'd0, 1'b1, 4'd9}) begin
            errors++; $display("FAIL orphan_ack: orph%b out%0d den%b src%0d, want 1 0 1 9",
                err_orphan_d, outstanding, ed_denied, ed_source);
        end
        apply_reset();
        drive(0, 0, 0, 0, 1, 6, 0, 9, 0); tick();
        checks++;
        if ({err_orphan_d, ed_valid, ed_opcode} !== {1'b0, 1'b1, 3'd6}) begin
            errors++; $display("FAIL releaseack: orph%b v%b op%0d, want 0 1 6", err_orphan_d, ed_valid, ed_opcode);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive(1, 4, 0, 2, 0, 0, 0, 0, 0); tick();
        drive(1, 4, 0, 2, 1, 0, 0, 2, 0); tick();
        checks++;
        if ({err_dup_source, err_orphan_d, outstanding, ea_first, ed_last} !=
            {1'b0, 1'b0, 5'd1, 1'b1, 1'b1}) begin
            errors++; $display("FAIL same_cycle: dup%b orph%b out%0d eaf%b edl%b, want 0 0 1 1 1",
                err_dup_source, err_orphan_d, outstanding, ea_first, ed_last);
        end
    endtask

    task automatic test_burst_err();
        apply_reset();
        drive(1, 0, 6, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 6, 2, 0, 0, 0, 0, 0); tick();
        checks++;
        if ({err_burst, ea_last, ea_beat} !== {1'b1, 1'b1, 8'd1}) begin
            errors++; $display("FAIL burst_src_change: err%b last%b beat%0d, want 1 1 1", err_burst, ea_last, ea_beat);
        end
        drive(1, 0, 6, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #2;
        checks++;
        if ({ea_valid, ea_first, ea_beat, outstanding, err_burst, err_dup_source} !== '0) begin
            errors++; $display("FAIL midburst_reset: v%b f%b beat%0d out%0d burst%b dup%b, want 0",
                ea_valid, ea_first, ea_beat, outstanding, err_burst, err_dup_source);
        end
        reset_n = 1'b1;
        drive(1, 0, 6, 1, 0, 0, 0, 0, 0); tick();
        checks++;
        if ({ea_first, ea_beat, ea_last} !== {1'b1, 8'd0, 1'b0}) begin
            errors++; $display("FAIL after_reset_first: f%b beat%0d l%b, want 1 0 0", ea_first, ea_beat, ea_last);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) apply_reset();
            a_valid = ($urandom_range(3, 0) != 0);
            a_ready = ($urandom_range(3, 0) != 0);
            d_valid = ($urandom_range(3, 0) != 0);
            d_ready = ($urandom_range(3, 0) != 0);
            d_denied = 1'($urandom_range(1, 0));
            if (m_a_pos == 0 || $urandom_range(15, 0) == 0) begin
                a_opcode = 3'($urandom_range(7, 0));
                a_size = 3'($urandom_range(7, 0));
                a_source = 4'($urandom_range(3, 0));
            end
            if (m_d_pos == 0 || $urandom_range(15, 0) == 0) begin
                d_opcode = 3'($urandom_range(7, 0));
                d_size = 3'($urandom_range(7, 0));
                d_source = 4'($urandom_range(3, 0));
            end
            model_predict();
            tick();
            checks++;
            if (ea_valid !== e_ea_v || ed_valid !== e_ed_v ||
                (e_ea_v && ({ea_first, ea_last, ea_beat, ea_source, ea_opcode} !==
                            {e_ea_f, e_ea_l, 8'(e_ea_beat), 4'(e_ea_src), 3'(e_ea_op)})) ||
                (e_ed_v && ({ed_first, ed_last, ed_beat, ed_source, ed_opcode, ed_denied} !==
                            {e_ed_f, e_ed_l, 8'(e_ed_beat), 4'(e_ed_src), 3'(e_ed_op), e_ed_den})) ||
                outstanding !== 5'(e_out) ||
                {err_dup_source, err_orphan_d, err_burst} !== {e_dup, e_orph, e_burst}) begin
                errors++;
                $display("FAIL random_cyc%0d: ea v%b f%b l%b b%0d | ed v%b f%b l%b b%0d | out%0d err%b%b%b ; want ea v%b f%b l%b b%0d | ed v%b f%b l%b b%0d | out%0d err%b%b%b",
                    cyc, ea_valid, ea_first, ea_last, ea_beat, ed_valid, ed_first, ed_last, ed_beat,
                    outstanding, err_dup_source, err_orphan_d, err_burst,
                    e_ea_v, e_ea_f, e_ea_l, e_ea_beat, e_ed_v, e_ed_f, e_ed_l, e_ed_beat,
                    e_out, e_dup, e_orph, e_burst);
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_get_ack_data();
        test_put_burst();
        test_dup_source();
        test_orphan();
        test_back_to_back();
        test_burst_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
